// File: rtl/dsp_wb_arbiter_pkg.sv
// Shared definitions for the DSP writeback arbiter: register-file
// geometry and the arbiter FSM state encoding.
package dsp_wb_arbiter_pkg;

   localparam int REG_WORD_LEN = 32;
   localparam int REG_ADDR_LEN = 5;

   typedef enum logic [1:0] {
      NORMAL     = 2'd0,
      DRAIN      = 2'd1,
      HOST_FORCE = 2'd2
   } wb_state_e;

endpackage

// File: rtl/dsp_wb_fifo.sv
// Synchronous FIFO holding {addr,data} MAC results, retired in push order.
// Ports: clk, rst (async high), push/din, pop/dout, full, empty, count.
module dsp_wb_fifo
   import dsp_wb_arbiter_pkg::*;
#(
   parameter int W     = REG_ADDR_LEN + REG_WORD_LEN,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             din,
   input  logic                     pop,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wp;
   logic [PW-1:0] rp;

   always_ff @(posedge clk) begin
      if (push) mem[wp] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop)  rp <= rp + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign dout  = mem[rp];
   assign full  = (count == (PW + 1)'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/dsp_wb_arbiter.sv
// Shares the register-file write port among pipeline, MAC FIFO and host.
// Ports: pipe_* (no backpressure), mac_* (valid/ready into FIFO),
// host_* (valid/ready), registered wb_* write, pipe_stall, fifo_count.
module dsp_wb_arbiter
   import dsp_wb_arbiter_pkg::*;
#(
   parameter int DW           = REG_WORD_LEN,
   parameter int AW           = REG_ADDR_LEN,
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        pipe_we,
   input  logic [AW-1:0]               pipe_addr,
   input  logic [DW-1:0]               pipe_data,
   input  logic                        mac_valid,
   output logic                        mac_ready,
   input  logic [AW-1:0]               mac_addr,
   input  logic [DW-1:0]               mac_data,
   input  logic                        host_valid,
   output logic                        host_ready,
   input  logic [AW-1:0]               host_addr,
   input  logic [DW-1:0]               host_data,
   output logic                        wb_en,
   output logic [AW-1:0]               wb_addr,
   output logic [DW-1:0]               wb_data,
   output logic                        pipe_stall,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   wb_state_e        st;
   wb_state_e        st_nxt;
   logic [SW-1:0]    starve;
   logic             starved;
   logic             sel_pipe;
   logic             sel_host;
   logic             sel_fifo;
   logic             push;
   logic             full;
   logic             empty;
   logic [AW+DW-1:0] head;
   logic [AW-1:0]    nxt_addr;
   logic [DW-1:0]    nxt_data;

   dsp_wb_fifo #(
      .W     (AW + DW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   ({mac_addr, mac_data}),
      .pop   (sel_fifo),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   assign mac_ready  = !full;
   assign push       = mac_valid && mac_ready;
   assign starved    = (starve == SW'(STARVE_LIMIT));
   assign host_ready = sel_host;

   // Pipeline always wins; a forced host slot beats a non-empty FIFO.
   always_comb begin
      sel_pipe = 1'b0;
      sel_host = 1'b0;
      sel_fifo = 1'b0;
      if (pipe_we)
         sel_pipe = 1'b1;
      else if (st == HOST_FORCE && host_valid)
         sel_host = 1'b1;
      else if (!empty)
         sel_fifo = 1'b1;
      else if (host_valid)
         sel_host = 1'b1;
   end

   always_comb begin
      nxt_addr = pipe_addr;
      nxt_data = pipe_data;
      if (sel_host) begin
         nxt_addr = host_addr;
         nxt_data = host_data;
      end else if (sel_fifo) begin
         {nxt_addr, nxt_data} = head;
      end
   end

   // Starvation is checked before fullness so the host slot comes first.
   always_comb begin
      st_nxt = st;
      case (st)
         NORMAL: begin
            if (starved)   st_nxt = HOST_FORCE;
            else if (full) st_nxt = DRAIN;
         end
         DRAIN: begin
            if (fifo_count <= CW'(FIFO_DEPTH / 2)) st_nxt = NORMAL;
         end
         HOST_FORCE: begin
            if (sel_host || !host_valid)
               st_nxt = full ? DRAIN : NORMAL;
         end
         default: st_nxt = NORMAL;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st         <= NORMAL;
         starve     <= '0;
         pipe_stall <= 1'b0;
         wb_en      <= 1'b0;
         wb_addr    <= '0;
         wb_data    <= '0;
      end else begin
         st         <= st_nxt;
         pipe_stall <= (st_nxt != NORMAL);
         if (host_valid && !sel_host) begin
            if (!starved) starve <= starve + 1'b1;
         end else begin
            starve <= '0;
         end
         wb_en <= sel_pipe || sel_host || sel_fifo;
         if (sel_pipe || sel_host || sel_fifo) begin
            wb_addr <= nxt_addr;
            wb_data <= nxt_data;
         end
      end
   end

endmodule

// File: tb/tb_dsp_wb_arbiter.sv
// Directed-vector bench for dsp_wb_arbiter (DW=32, AW=5, depth 4, limit 8).
// Inputs change 1ns after each rising edge; outputs are sampled there too.
module tb_dsp_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        pipe_we;
   logic [4:0]  pipe_addr;
   logic [31:0] pipe_data;
   logic        mac_valid;
   logic        mac_ready;
   logic [4:0]  mac_addr;
   logic [31:0] mac_data;
   logic        host_valid;
   logic        host_ready;
   logic [4:0]  host_addr;
   logic [31:0] host_data;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        pipe_stall;
   logic [2:0]  fifo_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   dsp_wb_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .pipe_we    (pipe_we),
      .pipe_addr  (pipe_addr),
      .pipe_data  (pipe_data),
      .mac_valid  (mac_valid),
      .mac_ready  (mac_ready),
      .mac_addr   (mac_addr),
      .mac_data   (mac_data),
      .host_valid (host_valid),
      .host_ready (host_ready),
      .host_addr  (host_addr),
      .host_data  (host_data),
      .wb_en      (wb_en),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .pipe_stall (pipe_stall),
      .fifo_count (fifo_count)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      pipe_we = 0; pipe_addr = 0; pipe_data = 0;
      mac_valid = 0; mac_addr = 0; mac_data = 0;
      host_valid = 0; host_addr = 0; host_data = 0;
      #12;
      total++;
      if ({wb_en, wb_addr, wb_data, pipe_stall, fifo_count, mac_ready}
          !== {1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 1'b1}) begin
         bad++;
         $display("FAIL reset: got en=%b a=%0d d=%h st=%b cnt=%0d rdy=%b want 0/0/0/0/0/1",
                  wb_en, wb_addr, wb_data, pipe_stall, fifo_count, mac_ready);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_priority;
      pipe_we = 1; pipe_addr = 3; pipe_data = 32'h11;
      mac_valid = 1; mac_addr = 5; mac_data = 32'h22;
      host_valid = 1; host_addr = 7; host_data = 32'h33;
      #1;
      total++;
      if (host_ready !== 1'b0) begin
         bad++;
         $display("FAIL prio_hr_n: got %b want 0", host_ready);
      end
      tick();
      pipe_we = 0; mac_valid = 0;
      total++;
      if ({wb_en, wb_addr, wb_data, fifo_count} !== {1'b1, 5'd3, 32'h11, 3'd1}) begin
         bad++;
         $display("FAIL prio_n1: got en=%b a=%0d d=%h cnt=%0d want 1/3/11/1",
                  wb_en, wb_addr, wb_data, fifo_count);
      end
      #1;
      total++;
      if (host_ready !== 1'b0) begin
         bad++;
         $display("FAIL prio_hr_n1: got %b want 0", host_ready);
      end
      tick();
      total++;
      if ({wb_en, wb_addr, wb_data, fifo_count} !== {1'b1, 5'd5, 32'h22, 3'd0}) begin
         bad++;
         $display("FAIL prio_n2: got en=%b a=%0d d=%h cnt=%0d want 1/5/22/0",
                  wb_en, wb_addr, wb_data, fifo_count);
      end
      #1;
      total++;
      if (host_ready !== 1'b1) begin
         bad++;
         $display("FAIL prio_hr_n2: got %b want 1", host_ready);
      end
      tick();
      host_valid = 0;
      total++;
      if ({wb_en, wb_addr, wb_data} !== {1'b1, 5'd7, 32'h33}) begin
         bad++;
         $display("FAIL prio_n3: got en=%b a=%0d d=%h want 1/7/33",
                  wb_en, wb_addr, wb_data);
      end
      #1;
      total++;
      if (host_ready !== 1'b0) begin
         bad++;
         $display("FAIL prio_hr_n3: got %b want 0", host_ready);
      end
   endtask

   task automatic test_idle;
      for (int i = 0; i < 10; i++) begin
         tick();
         total++;
         if ({wb_en, wb_addr, wb_data, pipe_stall} !== {1'b0, 5'd7, 32'h33, 1'b0}) begin
            bad++;
            $display("FAIL idle[%0d]: got en=%b a=%0d d=%h st=%b want 0/7/33/0",
                     i, wb_en, wb_addr, wb_data, pipe_stall);
         end
      end
   endtask

   task automatic test_push_pop;
      pipe_we = 1; pipe_addr = 2; pipe_data = 32'h1;
      mac_valid = 1; mac_addr = 10; mac_data = 32'hA0;
      tick();
      mac_addr = 11; mac_data = 32'hA1;
      tick();
      pipe_we = 0;
      mac_addr = 12; mac_data = 32'hA2;
      total++;
      if (fifo_count !== 3'd2) begin
         bad++;
         $display("FAIL pp_fill: got cnt=%0d want 2", fifo_count);
      end
      tick();
      mac_valid = 0;
      total++;
      if ({wb_en, wb_addr, wb_data, fifo_count} !== {1'b1, 5'd10, 32'hA0, 3'd2}) begin
         bad++;
         $display("FAIL pp_both: got en=%b a=%0d d=%h cnt=%0d want 1/10/a0/2",
                  wb_en, wb_addr, wb_data, fifo_count);
      end
      tick();
      total++;
      if ({wb_en, wb_addr, wb_data, fifo_count} !== {1'b1, 5'd11, 32'hA1, 3'd1}) begin
         bad++;
         $display("FAIL pp_pop1: got en=%b a=%0d d=%h cnt=%0d want 1/11/a1/1",
                  wb_en, wb_addr, wb_data, fifo_count);
      end
      tick();
      total++;
      if ({wb_en, wb_addr, wb_data, fifo_count, pipe_stall}
          !== {1'b1, 5'd12, 32'hA2, 3'd0, 1'b0}) begin
         bad++;
         $display("FAIL pp_pop2: got en=%b a=%0d d=%h cnt=%0d st=%b want 1/12/a2/0/0",
                  wb_en, wb_addr, wb_data, fifo_count, pipe_stall);
      end
   endtask

   task automatic test_fifo_full;
      pipe_we = 1; pipe_addr = 1;
      mac_valid = 1;
      for (int i = 0; i < 4; i++) begin
         mac_addr = 5'(20 + i); mac_data = 32'hC0 + 32'(i);
         pipe_data = 32'(i);
         tick();
         total++;
         if (fifo_count !== 3'(i + 1)) begin
            bad++;
            $display("FAIL full_fill[%0d]: got cnt=%0d want %0d", i, fifo_count, i + 1);
         end
      end
      mac_valid = 0;
      pipe_data = 32'hF0;
      total++;
      if ({mac_ready, pipe_stall} !== 2'b00) begin
         bad++;
         $display("FAIL full_ready: got rdy=%b st=%b want 0/0", mac_ready, pipe_stall);
      end
      tick();
      pipe_addr = 30; pipe_data = 32'h77;
      total++;
      if ({pipe_stall, fifo_count, wb_addr, wb_data} !== {1'b1, 3'd4, 5'd1, 32'hF0}) begin
         bad++;
         $display("FAIL full_stall: got st=%b cnt=%0d a=%0d d=%h want 1/4/1/f0",
                  pipe_stall, fifo_count, wb_addr, wb_data);
      end
      tick();
      pipe_we = 0;
      total++;
      if ({wb_en, wb_addr, wb_data, fifo_count} !== {1'b1, 5'd30, 32'h77, 3'd4}) begin
         bad++;
         $display("FAIL full_inflight: got en=%b a=%0d d=%h cnt=%0d want 1/30/77/4",
                  wb_en, wb_addr, wb_data, fifo_count);
      end
      for (int j = 0; j < 4; j++) begin
         tick();
         total++;
         if ({wb_en, wb_addr, wb_data, fifo_count, pipe_stall}
             !== {1'b1, 5'(20 + j), 32'hC0 + 32'(j), 3'(3 - j), (j < 2)}) begin
            bad++;
            $display("FAIL full_drain[%0d]: got en=%b a=%0d d=%h cnt=%0d st=%b want 1/%0d/%h/%0d/%b",
                     j, wb_en, wb_addr, wb_data, fifo_count, pipe_stall,
                     20 + j, 32'hC0 + j, 3 - j, j < 2);
         end
      end
   endtask

   task automatic test_starve;
      host_valid = 1; host_addr = 9; host_data = 32'h99;
      pipe_we = 1; pipe_addr = 14; pipe_data = 32'hE0;
      mac_valid = 1; mac_addr = 15; mac_data = 32'h55;
      for (int i = 1; i <= 8; i++) begin
         #1;
         total++;
         if (host_ready !== 1'b0) begin
            bad++;
            $display("FAIL starve_hr[%0d]: got %b want 0", i, host_ready);
         end
         tick();
         mac_valid = 0;
         pipe_data = pipe_data + 1;
         total++;
         if (pipe_stall !== 1'b0) begin
            bad++;
            $display("FAIL starve_nostall[%0d]: got %b want 0", i, pipe_stall);
         end
      end
      #1;
      total++;
      if (host_ready !== 1'b0) begin
         bad++;
         $display("FAIL starve_hr9: got %b want 0", host_ready);
      end
      tick();
      total++;
      if ({pipe_stall, wb_addr, wb_data} !== {1'b1, 5'd14, 32'hE8}) begin
         bad++;
         $display("FAIL starve_stall: got st=%b a=%0d d=%h want 1/14/e8",
                  pipe_stall, wb_addr, wb_data);
      end
      pipe_we = 0;
      #1;
      total++;
      if ({host_ready, fifo_count} !== {1'b1, 3'd1}) begin
         bad++;
         $display("FAIL starve_force: got hr=%b cnt=%0d want 1/1", host_ready, fifo_count);
      end
      tick();
      host_valid = 0;
      total++;
      if ({wb_en, wb_addr, wb_data, pipe_stall} !== {1'b1, 5'd9, 32'h99, 1'b0}) begin
         bad++;
         $display("FAIL starve_grant: got en=%b a=%0d d=%h st=%b want 1/9/99/0",
                  wb_en, wb_addr, wb_data, pipe_stall);
      end
      tick();
      total++;
      if ({wb_en, wb_addr, wb_data, fifo_count} !== {1'b1, 5'd15, 32'h55, 3'd0}) begin
         bad++;
         $display("FAIL starve_fifo: got en=%b a=%0d d=%h cnt=%0d want 1/15/55/0",
                  wb_en, wb_addr, wb_data, fifo_count);
      end
   endtask

   task automatic test_reset_mid;
      pipe_we = 1; pipe_addr = 4; pipe_data = 32'h4;
      mac_valid = 1; mac_addr = 6; mac_data = 32'h6;
      tick();
      tick();
      tick();
      pipe_we = 0; mac_valid = 0;
      total++;
      if ({wb_en, fifo_count} !== {1'b1, 3'd3}) begin
         bad++;
         $display("FAIL rmid_pre: got en=%b cnt=%0d want 1/3", wb_en, fifo_count);
      end
      #3;
      rst = 1'b1;
      #1;
      total++;
      if ({wb_en, fifo_count, pipe_stall, mac_ready} !== {1'b0, 3'd0, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL rmid_async: got en=%b cnt=%0d st=%b rdy=%b want 0/0/0/1",
                  wb_en, fifo_count, pipe_stall, mac_ready);
      end
      #2;
      rst = 1'b0;
      tick();
      total++;
      if ({wb_en, fifo_count} !== {1'b0, 3'd0}) begin
         bad++;
         $display("FAIL rmid_after: got en=%b cnt=%0d want 0/0", wb_en, fifo_count);
      end
   endtask

   initial begin
      test_reset();
      test_priority();
      test_idle();
      test_push_pop();
      test_fifo_full();
      test_starve();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dsp_wb_arbiter.md
Name: dsp_wb_arbiter

Overview:
Owns the single register-file write port behind the DSP writeback stage and shares it among three writers: the in-order pipeline writeback (highest priority, no backpressure), the multi-cycle MAC result path (buffered in a small FIFO), and the host/debug write port. It outputs one registered write per cycle toward the writeback stage. It stalls the pipeline when the MAC FIFO is full or the host has been starved.

Parameters:
DW, `REG_WORD_LEN, register data width
AW, `REG_ADDR_LEN, register address width
FIFO_DEPTH, 4, MAC result FIFO entries (power of two, >=2)
STARVE_LIMIT, 8, consecutive ungranted host cycles before a forced host slot

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous active-high reset
pipe_we  in  1  pipeline writeback request, must be accepted in the same cycle
pipe_addr  in  AW  pipeline destination register
pipe_data  in  DW  pipeline write data
mac_valid  in  1  MAC result valid
mac_ready  out  1  MAC FIFO can accept this cycle
mac_addr  in  AW  MAC destination register
mac_data  in  DW  MAC result
host_valid  in  1  host write request, held until granted
host_ready  out  1  host write granted this cycle
host_addr  in  AW  host destination register
host_data  in  DW  host write data
wb_en  out  1  registered write request to writeback stage (becomes write_back_en)
wb_addr  out  AW  registered destination
wb_data  out  DW  registered data
pipe_stall  out  1  registered; upstream holds issue so pipe_we is 0 next cycle
fifo_count  out  clog2(FIFO_DEPTH)+1  MAC FIFO occupancy

Behaviour:
- Reset (async, rst=1): wb_en=0, wb_addr=0, wb_data=0, pipe_stall=0, FIFO empty (fifo_count=0), starve counter=0, state=NORMAL. Reset asserted mid-operation discards all FIFO contents and any pending host grant.
- Latency: the winner selected in cycle N appears on wb_* at edge N+1. Exactly one write per cycle at most. wb_en=0 when nothing is selected, and wb_addr/wb_data hold their last value.
- mac_ready = (fifo_count != FIFO_DEPTH). There is no full pass-through: a push and a pop when full is impossible because ready is low. A push and pop in the same cycle when not full leaves the count unchanged.
- Per-cycle priority: pipe_we > forced host (state HOST_FORCE) > FIFO head > host.
- host_ready is combinational, high only in the cycle the host wins. The host interface must keep addr/data stable while valid && !ready.
- Starve counter: increments each cycle host_valid && !host_ready, saturating at STARVE_LIMIT. It clears on a host grant or when host_valid=0.
- FSM states:
  - NORMAL: priority as above. Go to HOST_FORCE when the counter reaches STARVE_LIMIT. Go to DRAIN when fifo_count==FIFO_DEPTH.
  - DRAIN: pipe_stall=1. The FIFO head is written every cycle pipe_we=0. Return to NORMAL when fifo_count<=FIFO_DEPTH/2.
  - HOST_FORCE: pipe_stall=1. The host is granted on the first cycle pipe_we=0, even if the FIFO is non-empty. The counter then clears and the FSM returns to NORMAL, or to DRAIN if the FIFO is full.
  - If both conditions arise together, HOST_FORCE is taken first.
- pipe_stall is registered, so one in-flight pipe_we may still arrive after assertion; it always wins. A pipe_we arriving while pipe_stall is high is not an error.
- Write ordering across sources is the issue logic's responsibility; the arbiter does no address comparison. FIFO entries retire in push order.

Decomposition:
- definitions.v gains REG_ADDR_LEN (REG_WORD_LEN already lives there) and the three FSM state encodings (NORMAL=2'd0, DRAIN=2'd1, HOST_FORCE=2'd2).
- Natural sub-module: dsp_wb_fifo, a synchronous FIFO of {addr,data} with push/pop/full/empty/count, async active-high reset.
- Output mux, starve counter and FSM live in the top.

Test Plan:
- Reset: assert rst mid-cycle with FIFO holding 3 entries -> wb_en=0, fifo_count=0, pipe_stall=0 immediately, with no clock edge needed.
- Priority: in one cycle, pipe_we(r3,0x11), mac_valid(r5,0x22), host_valid(r7,0x33) -> wb=r3/0x11 at N+1, r5/0x22 at N+2, r7/0x33 at N+3; host_ready high only in cycle N+2.
- FIFO full: stream mac_valid with pipe_we=1 every cycle, FIFO_DEPTH=4 -> mac_ready=0 at count 4 and pipe_stall=1 next edge. Four MAC writes then retire in order; NORMAL returns at count 2.
- Starvation: host_valid=1 with pipe_we and FIFO traffic continuous -> after 8 ungranted cycles pipe_stall=1. Host is granted on the first pipe_we=0 cycle and the counter returns to 0.
- Simultaneous push/pop at count 2 -> count stays 2, head written, new entry at tail.
- Idle: no requests for 10 cycles -> wb_en=0 throughout, wb_addr/wb_data unchanged.
